ts_os_checker: RTL and testbench

- Sits directly downstream of the receive ordered-set decoder.
- Consumes its lane-arranged 2048-bit ordered-set bus.
- Classifies each active lane's 16-symbol set as TS1, TS2 or other, and tracks consecutive identical training sets per lane.
- Presents registered TS fields and "N consecutive received" qualifiers to the LTSSM.

---
 rtl/ts_os_checker_pkg.sv | 35 +++
 rtl/ts_lane_checker.sv | 52 +++++
 rtl/ts_os_checker.sv | 93 +++++++++
 tb/tb_ts_os_checker.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_os_checker_pkg.sv
// ts_os_checker_pkg: ordered-set symbol constants, TS class encoding and lane classification,
// shared between the receive ordered-set decoder and the TS checker.
package ts_os_checker_pkg;
    localparam int LANE_W  = 128;
    localparam int SYM_W   = 8;
    localparam int TS_SYMS = 16;

    localparam logic [7:0] COM    = 8'hBC;
    localparam logic [7:0] PAD    = 8'hF7;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;
    localparam logic [7:0] SKP    = 8'h1C;

    localparam logic [7:0] G3_TS1_ID = 8'h1E;
    localparam logic [7:0] G3_TS2_ID = 8'h2D;
    localparam logic [7:0] G3_SKP_ID = 8'hAA;

    typedef enum logic [1:0] {
        TS_OTHER = 2'b00,
        TS_1     = 2'b01,
        TS_2     = 2'b10
    } ts_type_t;

    // Value-only match: the decoder strips K/D flags before this point.
    function automatic ts_type_t classify(input logic [LANE_W-1:0] s);
        logic t1, t2;
        t1 = (s[SYM_W-1:0] == COM);
        t2 = t1;
        for (int k = 6; k < TS_SYMS; k++) begin
            t1 &= (s[k*SYM_W +: SYM_W] == TS1_ID);
            t2 &= (s[k*SYM_W +: SYM_W] == TS2_ID);
        end
        return t1 ? TS_1 : t2 ? TS_2 : TS_OTHER;
    endfunction
endpackage

// File: rtl/ts_lane_checker.sv
// ts_lane_checker: per-lane TS classification, stored copy of symbols 1..5 and saturating
// consecutive-identical counter; reached reflects the post-update count.
module ts_lane_checker
    import ts_os_checker_pkg::*;
#(
    parameter int COUNT_TARGET = 8,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              os_valid,
    input  logic              clear,
    input  logic              active,
    input  logic [LANE_W-1:0] data,
    output logic [1:0]        cls,
    output logic              reached,
    output logic [7:0]        sym1,
    output logic [7:0]        sym2
);
    logic [CNT_W-1:0] count, next_count;
    logic [1:0]       stored_cls;
    logic [39:0]      stored_info, info;
    logic             same;

    assign cls  = classify(data);
    assign info = data[47:8];
    assign sym1 = data[15:8];
    assign sym2 = data[23:16];

    // A clear in the same cycle makes this set the first of a new run.
    always_comb begin
        same       = !clear && cls == stored_cls && info == stored_info;
        next_count = (cls == TS_OTHER) ? '0 :
                     same ? count + CNT_W'(!(&count)) : CNT_W'(1);
        reached    = next_count >= CNT_W'(COUNT_TARGET);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            stored_cls  <= TS_OTHER;
            stored_info <= '0;
        end else if (os_valid && active) begin
            count       <= next_count;
            stored_cls  <= cls;
            stored_info <= info;
        end else if (clear || !active) begin
            count      <= '0;
            stored_cls <= TS_OTHER;
        end
    end
endmodule

// File: rtl/ts_os_checker.sv
// ts_os_checker: masks lanes to the active link width, AND-reduces per-lane TS status and
// registers lane-0 TS fields plus the consecutive-received qualifiers for the LTSSM.
module ts_os_checker
    import ts_os_checker_pkg::*;
#(
    parameter int MAX_LANES    = 16,
    parameter int COUNT_TARGET = 8,
    parameter int CNT_W        = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        os_valid,
    input  logic [MAX_LANES*LANE_W-1:0] os_data,
    input  logic [4:0]                  num_lanes,
    input  logic                        clear,
    output logic                        ts_valid,
    output logic [1:0]                  ts_type,
    output logic [7:0]                  link_num,
    output logic [7:0]                  lane_num,
    output logic [7:0]                  n_fts,
    output logic [7:0]                  rate_id,
    output logic [7:0]                  train_ctrl,
    output logic                        link_pad,
    output logic                        lane_pad,
    output logic                        lane_order_ok,
    output logic                        ts1_rcvd,
    output logic                        ts2_rcvd
);
    logic [4:0]           width;
    logic [MAX_LANES-1:0] active, reached, hit1, hit2, link_is_pad, lane_is_pad, in_order;
    logic [1:0]           cls  [MAX_LANES];
    logic [7:0]           sym1 [MAX_LANES];
    logic [7:0]           sym2 [MAX_LANES];

    assign width = (num_lanes inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}) ? num_lanes : 5'd1;

    // Inactive lanes read as "satisfied" so they drop out of every AND-reduction.
    for (genvar i = 0; i < MAX_LANES; i++) begin : g_lane
        ts_lane_checker #(.COUNT_TARGET(COUNT_TARGET), .CNT_W(CNT_W)) u_lane (
            .clk      (clk),
            .reset    (reset),
            .os_valid (os_valid),
            .clear    (clear),
            .active   (active[i]),
            .data     (os_data[i*LANE_W +: LANE_W]),
            .cls      (cls[i]),
            .reached  (reached[i]),
            .sym1     (sym1[i]),
            .sym2     (sym2[i])
        );
        assign active[i]      = i < int'(width);
        assign hit1[i]        = !active[i] || (cls[i] == TS_1 && reached[i]);
        assign hit2[i]        = !active[i] || (cls[i] == TS_2 && reached[i]);
        assign link_is_pad[i] = !active[i] || sym1[i] == PAD;
        assign lane_is_pad[i] = !active[i] || sym2[i] == PAD;
        assign in_order[i]    = !active[i] || sym2[i] == 8'(i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_valid      <= 1'b0;
            ts_type       <= TS_OTHER;
            link_num      <= '0;
            lane_num      <= '0;
            n_fts         <= '0;
            rate_id       <= '0;
            train_ctrl    <= '0;
            link_pad      <= 1'b0;
            lane_pad      <= 1'b0;
            lane_order_ok <= 1'b0;
            ts1_rcvd      <= 1'b0;
            ts2_rcvd      <= 1'b0;
        end else begin
            ts_valid <= os_valid;
            if (os_valid) begin
                ts_type       <= cls[0];
                link_num      <= sym1[0];
                lane_num      <= sym2[0];
                n_fts         <= os_data[31:24];
                rate_id       <= os_data[39:32];
                train_ctrl    <= os_data[47:40];
                link_pad      <= cls[0] != TS_OTHER && (&link_is_pad);
                lane_pad      <= cls[0] != TS_OTHER && (&lane_is_pad);
                lane_order_ok <= cls[0] != TS_OTHER && (&in_order);
                ts1_rcvd      <= &hit1;
                ts2_rcvd      <= &hit2;
            end else if (clear) begin
                ts1_rcvd <= 1'b0;
                ts2_rcvd <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ts_os_checker.sv
// tb_ts_os_checker: scenario tasks plus randomized traffic, checked against a run-length
// model of consecutive identical training sets per lane.
module tb_ts_os_checker;
    logic          clk = 1'b0;
    logic          reset;
    logic          os_valid;
    logic [2047:0] os_data;
    logic [4:0]    num_lanes;
    logic          clear;
    logic          ts_valid, link_pad, lane_pad, lane_order_ok, ts1_rcvd, ts2_rcvd;
    logic [1:0]    ts_type;
    logic [7:0]    link_num, lane_num, n_fts, rate_id, train_ctrl;

    int checks = 0;
    int failures = 0;

    ts_os_checker dut (
        .clk(clk), .reset(reset), .os_valid(os_valid), .os_data(os_data),
        .num_lanes(num_lanes), .clear(clear), .ts_valid(ts_valid), .ts_type(ts_type),
        .link_num(link_num), .lane_num(lane_num), .n_fts(n_fts), .rate_id(rate_id),
        .train_ctrl(train_ctrl), .link_pad(link_pad), .lane_pad(lane_pad),
        .lane_order_ok(lane_order_ok), .ts1_rcvd(ts1_rcvd), .ts2_rcvd(ts2_rcvd)
    );

    always #5 clk = ~clk;

    // Reference model: run length of identical TS sets per lane, and expected outputs.
    int          m_run  [16];
    logic [1:0]  m_cls  [16];
    logic [39:0] m_info [16];
    logic        e_valid, e_lpad, e_npad, e_ord, e_t1, e_t2;
    logic [1:0]  e_type;
    logic [7:0]  e_link, e_lane, e_nfts, e_rate, e_ctrl;
    logic [47:0] dut_v, exp_v;

    assign dut_v = {ts_valid, ts_type, link_num, lane_num, n_fts, rate_id, train_ctrl,
                    link_pad, lane_pad, lane_order_ok, ts1_rcvd, ts2_rcvd};
    assign exp_v = {e_valid, e_type, e_link, e_lane, e_nfts, e_rate, e_ctrl,
                    e_lpad, e_npad, e_ord, e_t1, e_t2};

    function automatic logic [1:0] ref_class(input logic [127:0] s);
        int a = 0;
        int b = 0;
        for (int k = 6; k < 16; k++) begin
            if (s[k*8 +: 8] == 8'h4A) a++;
            if (s[k*8 +: 8] == 8'h45) b++;
        end
        if (s[7:0] != 8'hBC) return 2'd0;
        return (a == 10) ? 2'd1 : (b == 10) ? 2'd2 : 2'd0;
    endfunction

    function automatic logic [127:0] mk(input int t, input logic [7:0] link, lane, nfts, rate, ctrl);
        logic [7:0] id;
        id = (t == 1) ? 8'h4A : 8'h45;
        return {{10{id}}, ctrl, rate, nfts, lane, link, 8'hBC};
    endfunction

    function automatic void model_reset();
        for (int l = 0; l < 16; l++) begin
            m_run[l] = 0; m_cls[l] = 0; m_info[l] = '0;
        end
        {e_valid, e_type, e_link, e_lane, e_nfts, e_rate, e_ctrl, e_lpad, e_npad, e_ord, e_t1, e_t2} = '0;
    endfunction

    function automatic void model_edge(input logic v, c, input logic [2047:0] d, input logic [4:0] nl);
        int n;
        logic [127:0] s;
        logic [1:0] cc;
        logic a1, a2, lp, np, od;
        n = (nl == 1 || nl == 2 || nl == 4 || nl == 8 || nl == 16) ? int'(nl) : 1;
        for (int l = 0; l < 16; l++) begin
            s = d[l*128 +: 128];
            cc = ref_class(s);
            if (l >= n) begin
                m_run[l] = 0; m_cls[l] = 0;
            end else if (v) begin
                if (cc == 0) m_run[l] = 0;
                else if (!c && cc == m_cls[l] && s[47:8] == m_info[l]) m_run[l] = (m_run[l] < 15) ? m_run[l] + 1 : 15;
                else m_run[l] = 1;
                m_cls[l] = cc; m_info[l] = s[47:8];
            end else if (c) begin
                m_run[l] = 0; m_cls[l] = 0;
            end
        end
        e_valid = v;
        if (v) begin
            a1 = 1; a2 = 1; lp = 1; np = 1; od = 1;
            for (int l = 0; l < n; l++) begin
                s = d[l*128 +: 128];
                a1 &= (m_cls[l] == 1 && m_run[l] >= 8);
                a2 &= (m_cls[l] == 2 && m_run[l] >= 8);
                lp &= (s[15:8] == 8'hF7);
                np &= (s[23:16] == 8'hF7);
                od &= (s[23:16] == 8'(l));
            end
            e_type = m_cls[0];
            e_link = d[15:8]; e_lane = d[23:16]; e_nfts = d[31:24]; e_rate = d[39:32]; e_ctrl = d[47:40];
            e_lpad = (e_type != 0) && lp; e_npad = (e_type != 0) && np; e_ord = (e_type != 0) && od;
            e_t1 = a1; e_t2 = a2;
        end else if (c) begin
            e_t1 = 0; e_t2 = 0;
        end
    endfunction

    task automatic step(input logic v, c, input logic [2047:0] d, input logic [4:0] nl);
        os_valid = v; clear = c; os_data = d; num_lanes = nl;
        @(posedge clk);
        model_edge(v, c, d, nl);
        #1;
        os_valid = 0; clear = 0;
    endtask

    task automatic test_reset();
        reset = 0; os_valid = 0; clear = 0; os_data = '0; num_lanes = 5'd1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_v !== 48'h0) begin failures++; $display("FAIL reset: got %h want 0", dut_v); end
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_x1_ts1();
        logic [2047:0] d;
        d = '0;
        d[127:0] = mk(1, 8'h05, 8'h00, 8'h20, 8'h02, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, d, 5'd1);
            checks++;
            if (dut_v !== exp_v) begin failures++; $display("FAIL x1_ts1 model %0d: got %h want %h", i, dut_v, exp_v); end
            checks++;
            if ({ts_valid, ts_type, link_num, ts1_rcvd} !== {1'b1, 2'b01, 8'h05, i == 7}) begin
                failures++; $display("FAIL x1_ts1 fields %0d: got %b/%b/%h/%b", i, ts_valid, ts_type, link_num, ts1_rcvd);
            end
        end
        step(0, 0, d, 5'd1);
        checks++;
        if ({ts_valid, ts1_rcvd, link_num} !== {1'b0, 1'b1, 8'h05}) begin
            failures++; $display("FAIL x1_hold: got valid=%b rcvd=%b link=%h want 0/1/05", ts_valid, ts1_rcvd, link_num);
        end
    endtask

    task automatic test_x4_ts2();
        logic [2047:0] d;
        for (int i = 0; i < 12; i++) begin
            d = '0;
            for (int l = 0; l < 4; l++)
                d[l*128 +: 128] = mk(2, 8'h01, 8'(l), (l == 2 && i >= 4) ? 8'h30 : 8'h20, 8'h02, 8'h00);
            step(1, 0, d, 5'd4);
            checks++;
            if (dut_v !== exp_v) begin failures++; $display("FAIL x4_ts2 model %0d: got %h want %h", i, dut_v, exp_v); end
            checks++;
            if ({ts_type, lane_order_ok, ts2_rcvd, ts1_rcvd} !== {2'b10, 1'b1, i == 11, 1'b0}) begin
                failures++; $display("FAIL x4_ts2 flags %0d: got type=%b ord=%b ts2=%b ts1=%b", i, ts_type, lane_order_ok, ts2_rcvd, ts1_rcvd);
            end
        end
    endtask

    task automatic test_pad();
        logic [2047:0] d;
        d = '0;
        for (int l = 0; l < 2; l++) d[l*128 +: 128] = mk(1, 8'hF7, 8'hF7, 8'h20, 8'h02, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, d, 5'd2);
            checks++;
            if ({link_pad, lane_pad, lane_order_ok, ts1_rcvd} !== {1'b1, 1'b1, 1'b0, i == 7} || dut_v !== exp_v) begin
                failures++; $display("FAIL pad %0d: got %h want %h", i, dut_v, exp_v);
            end
        end
        d[79:72] = 8'h00;
        d[128+72 +: 8] = 8'h00;
        step(1, 0, d, 5'd2);
        checks++;
        if ({ts_valid, ts_type, link_pad, lane_pad, lane_order_ok, ts1_rcvd} !== 7'b1000000 || dut_v !== exp_v) begin
            failures++; $display("FAIL pad_bad_set: got %h want %h", dut_v, exp_v);
        end
    endtask

    task automatic test_clear();
        logic [2047:0] d;
        d = '0;
        d[127:0] = mk(1, 8'h05, 8'h00, 8'h20, 8'h02, 8'h00);
        for (int i = 0; i < 8; i++) step(1, 0, d, 5'd1);
        checks++;
        if (ts1_rcvd !== 1'b1) begin failures++; $display("FAIL clear_pre: got ts1_rcvd=%b want 1", ts1_rcvd); end
        step(0, 1, d, 5'd1);
        checks++;
        if ({ts_valid, ts1_rcvd, ts_type, link_num} !== {1'b0, 1'b0, 2'b01, 8'h05} || dut_v !== exp_v) begin
            failures++; $display("FAIL clear_alone: got %h want %h", dut_v, exp_v);
        end
        step(1, 1, d, 5'd1);
        checks++;
        if ({ts_valid, ts1_rcvd} !== 2'b10 || dut_v !== exp_v) begin
            failures++; $display("FAIL clear_with_valid: got %h want %h", dut_v, exp_v);
        end
        for (int i = 0; i < 7; i++) begin
            step(1, 0, d, 5'd1);
            checks++;
            if (ts1_rcvd !== (i == 6) || dut_v !== exp_v) begin
                failures++; $display("FAIL clear_rebuild %0d: got %h want %h", i, dut_v, exp_v);
            end
        end
    endtask

    task automatic test_width();
        logic [2047:0] d;
        logic [4:0] nls [3];
        nls[0] = 5'd16; nls[1] = 5'd1; nls[2] = 5'd3;
        for (int w = 0; w < 3; w++) begin
            step(0, 1, '0, nls[w]);
            for (int i = 0; i < 8; i++) begin
                for (int k = 0; k < 64; k++) d[k*32 +: 32] = $urandom;
                d[127:0] = mk(1, 8'h07, 8'h00, 8'h10, 8'h02, 8'h00);
                step(1, 0, d, nls[w]);
                checks++;
                if (ts1_rcvd !== (w != 0 && i == 7) || dut_v !== exp_v) begin
                    failures++; $display("FAIL width nl=%0d strobe %0d: got %h want %h", nls[w], i, dut_v, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2047:0] d;
        d = '0;
        d[127:0] = mk(1, 8'h09, 8'h00, 8'h20, 8'h02, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, d, 5'd1);
        os_valid = 1; os_data = d;
        #2 reset = 0;
        #1;
        model_reset();
        checks++;
        if (dut_v !== 48'h0) begin failures++; $display("FAIL reset_mid: got %h want 0", dut_v); end
        @(negedge clk);
        os_valid = 0;
        reset = 1;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, d, 5'd1);
            checks++;
            if (ts1_rcvd !== (i == 7) || dut_v !== exp_v) begin
                failures++; $display("FAIL reset_rebuild %0d: got %h want %h", i, dut_v, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [2047:0] d;
        logic [4:0] nl;
        logic [4:0] nl_pick [8];
        int r;
        nl_pick[0] = 1; nl_pick[1] = 2; nl_pick[2] = 4; nl_pick[3] = 8;
        nl_pick[4] = 16; nl_pick[5] = 3; nl_pick[6] = 0; nl_pick[7] = 5;
        d = '0;
        nl = 5'd4;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 39) == 0) nl = nl_pick[$urandom_range(0, 7)];
            for (int l = 0; l < 16; l++) begin
                if ($urandom_range(0, 15) == 0) begin
                    r = $urandom_range(0, 7);
                    if (r < 6)
                        d[l*128 +: 128] = mk((r < 3) ? 1 : 2, ($urandom_range(0, 1) != 0) ? 8'hF7 : 8'h03,
                                             ($urandom_range(0, 3) != 0) ? 8'(l) : 8'hF7, 8'h20,
                                             8'h02, 8'($urandom_range(0, 1)));
                    else
                        d[l*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, d, nl);
            checks++;
            if (dut_v !== exp_v) begin failures++; $display("FAIL random cycle %0d: got %h want %h", c, dut_v, exp_v); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_x1_ts1();
        test_x4_ts2();
        test_pad();
        test_clear();
        test_width();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
